// File: rtl/uart_rx_frame.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_frame : parametrised UART receiver with 3-sample voting, |
// | parity/framing/break detection and a valid/ready output register.|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int TW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;

  localparam logic [TW-1:0] C_T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] C_T_MID_M1 = TW'(MID - 1);
  localparam logic [TW-1:0] C_T_MID    = TW'(MID);
  localparam logic [TW-1:0] C_T_MID_P1 = TW'(MID + 1);
  localparam logic [3:0]    C_BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic          C_STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] C_IDLE      = 3'd0;
  localparam logic [2:0] C_START     = 3'd1;
  localparam logic [2:0] C_DATA      = 3'd2;
  localparam logic [2:0] C_PARITY    = 3'd3;
  localparam logic [2:0] C_STOP      = 3'd4;
  localparam logic [2:0] C_WAIT_HIGH = 3'd5;

  logic                 sync1_q, rx_s_q;
  logic                 s0_q, s1_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 fe_q, fe_d;

  logic w_last, w_vote, w_maj;
  logic w_done, w_fe_final, w_pe, w_brk, w_par_x;
  logic w_xfer, w_load;

  assign w_last = (timer_q == C_T_LAST);
  assign w_vote = (timer_q == C_T_MID_P1);
  assign w_maj  = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

  // State register, input synchroniser and vote sample holders
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      state_q    <= C_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      sync1_q    <= serial_i;
      rx_s_q     <= sync1_q;
      if (timer_q == C_T_MID_M1) s0_q <= rx_s_q;
      if (timer_q == C_T_MID)    s1_q <= rx_s_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      fe_q       <= fe_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    timer_d    = w_last ? '0 : timer_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fe_d       = fe_q;
    case (state_q)
      C_IDLE: begin
        timer_d    = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        fe_d       = 1'b0;
        par_d      = 1'b0;
        if (!rx_s_q) state_d = C_START;
      end
      C_START: begin
        if (w_vote && w_maj) state_d = C_IDLE;
        else if (w_last) begin
          state_d   = C_DATA;
          bit_idx_d = '0;
        end
      end
      C_DATA: begin
        for (int i = 0; i < DATA_BITS; i++)
          if (w_vote && bit_idx_q == 4'(i)) shift_d[i] = w_maj;
        if (w_last) begin
          if (bit_idx_q == C_BIT_LAST) state_d = (PARITY != 0) ? C_PARITY : C_STOP;
          else bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      C_PARITY: begin
        if (w_vote) par_d = w_maj;
        if (w_last) state_d = C_STOP;
      end
      C_STOP: begin
        if (w_vote && !w_maj) fe_d = 1'b1;
        // The final stop bit ends the frame mid-bit so the next start edge is not missed
        if (stop_idx_q == C_STOP_LAST) begin
          if (w_vote) state_d = w_fe_final ? C_WAIT_HIGH : C_IDLE;
        end else if (w_last) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      C_WAIT_HIGH: begin
        timer_d = '0;
        if (rx_s_q) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Output logic: frame completion and status flags
  always_comb begin
    w_done     = (state_q == C_STOP) && (stop_idx_q == C_STOP_LAST) && w_vote;
    w_fe_final = fe_q | ~w_maj;
    w_par_x    = (^shift_q) ^ par_q;
    if (PARITY == 1)      w_pe = ~w_par_x;
    else if (PARITY == 2) w_pe = w_par_x;
    else                  w_pe = 1'b0;
    w_brk  = w_fe_final & ~(|shift_q) & ((PARITY == 0) | ~par_q);
    w_xfer = valid_o & ready_i;
    w_load = w_done & (~valid_o | w_xfer);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
      overrun_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      overrun_o <= w_done & ~w_load;
      busy_o    <= (state_q != C_IDLE);
      if (w_load) begin
        data_o       <= shift_q;
        parity_err_o <= w_pe;
        frame_err_o  <= w_fe_final;
        break_o      <= w_brk;
        valid_o      <= 1'b1;
      end else if (w_xfer) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// tb_uart_rx_frame : scoreboard bench for uart_rx_frame with 8 data bits,
// even parity and one stop bit at 16 clocks per bit.
module tb_uart_rx_frame;

  // serial_i driven at a negedge reaches START after 3 edges; valid_o 170 edges later
  localparam int RISE_LAT = 173;
  localparam int FRAME_CYC = 11 * 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, parity_err_o, frame_err_o, break_o, overrun_o, busy_o;

  uart_rx_frame #(
    .CLKS_PER_BIT(16),
    .DATA_BITS   (8),
    .PARITY      (2),
    .STOP_BITS   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_i    (serial_i),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .break_o     (break_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
    int         rise;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ovr_cnt = 0;
  logic busy_seen = 1'b0;
  logic pv = 1'b0;
  logic pr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever a new word is presented
  always @(posedge clk) begin
    #1;
    ovr_cnt += int'(overrun_o);
    if (busy_o) busy_seen = 1'b1;
    if (valid_o && (!pv || pr)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got data=0x%0h, expected no word", data_o);
      end else begin
        e_m = exp_q.pop_front();
        chk("data_o", int'(data_o), int'(e_m.d));
        chk("parity_err_o", int'(parity_err_o), int'(e_m.pe));
        chk("frame_err_o", int'(frame_err_o), int'(e_m.fe));
        chk("break_o", int'(break_o), int'(e_m.brk));
        if (e_m.rise >= 0) chk("valid_rise_cycle", cyc, e_m.rise);
      end
    end
    pv = valid_o;
    pr = ready_i;
  end

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe,
                          input logic brk, input int rise);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.brk = brk; e.rise = rise;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; drives ncyc cycles of a frame (start, data, parity, stop)
  task automatic send_frame(input logic [7:0] d, input logic par, input int glitch_bit,
                            input int ncyc);
    logic [10:0] fb;
    logic        v;
    fb = {1'b1, par, d, 1'b0};
    for (int k = 0; k < ncyc; k++) begin
      v = fb[k / 16];
      if ((k / 16) == glitch_bit + 1 && (k % 16) == 8) v = ~v;
      serial_i = v;
      @(negedge clk);
    end
    serial_i = 1'b1;
  endtask

  task automatic idle(input int n);
    serial_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_o"}, int'(data_o), 0);
    chk({tag, "_valid_o"}, int'(valid_o), 0);
    chk({tag, "_parity_err_o"}, int'(parity_err_o), 0);
    chk({tag, "_frame_err_o"}, int'(frame_err_o), 0);
    chk({tag, "_break_o"}, int'(break_o), 0);
    chk({tag, "_overrun_o"}, int'(overrun_o), 0);
    chk({tag, "_busy_o"}, int'(busy_o), 0);
  endtask

  initial begin
    int o0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    idle(5);

    // 0xA5, correct even parity, with a glitch at timer 8 of data bit 3
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0, cyc + RISE_LAT);
    send_frame(8'hA5, 1'b0, 3, FRAME_CYC);
    idle(20);

    // 0xA5 with wrong parity bit
    push_exp(8'hA5, 1'b1, 1'b0, 1'b0, cyc + RISE_LAT);
    send_frame(8'hA5, 1'b1, -1, FRAME_CYC);
    idle(20);

    // False start: 5 low cycles
    busy_seen = 1'b0;
    serial_i = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    chk("false_start_busy_seen", int'(busy_seen), 1);
    chk("false_start_busy_after", int'(busy_o), 0);
    chk("false_start_valid", int'(valid_o), 0);

    // Break: line low for 12 bit periods
    push_exp(8'h00, 1'b0, 1'b1, 1'b1, -1);
    serial_i = 1'b0;
    repeat (12 * 16) @(negedge clk);
    idle(60);
    chk("break_no_second_valid", int'(valid_o), 0);
    push_exp(8'h5A, 1'b0, 1'b0, 1'b0, cyc + RISE_LAT);
    send_frame(8'h5A, 1'b0, -1, FRAME_CYC);
    idle(20);

    // Overrun: consumer stalled, two back-to-back frames
    ready_i = 1'b0;
    o0 = ovr_cnt;
    push_exp(8'h11, 1'b0, 1'b0, 1'b0, cyc + RISE_LAT);
    send_frame(8'h11, 1'b0, -1, FRAME_CYC);
    send_frame(8'h22, 1'b0, -1, FRAME_CYC);
    idle(20);
    chk("overrun_pulses", ovr_cnt - o0, 1);
    chk("overrun_held_data", int'(data_o), 8'h11);
    chk("overrun_held_valid", int'(valid_o), 1);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("valid_drop_after_accept", int'(valid_o), 0);
    ready_i = 1'b1;
    idle(5);

    // Reset during data bit 3, then a clean frame
    send_frame(8'h3C, 1'b0, -1, 4 * 16 + 8);
    serial_i = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midframe_reset");
    reset = 1'b0;
    idle(10);
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0, cyc + RISE_LAT);
    send_frame(8'h3C, 1'b0, -1, FRAME_CYC);
    idle(20);

    chk("pending_words", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds:
- configurable data width, parity and stop bits;
- a 2-flop input synchroniser and 3-sample majority voting;
- parity, framing and break detection;
- a one-entry valid/ready output holding register with overrun reporting.

It sits between the external RX pin and the byte-consumer logic. Everything runs in one clock domain.

## Interface
- CLKS_PER_BIT, 16, clocks per bit period; legal range is ≥4.
- DATA_BITS, 8, data bits per frame; legal range is 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.

- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- serial_i  in  1  asynchronous RX line; idles high.
- ready_i  in  1  consumer accepts the held word.
- data_o  out  DATA_BITS  received word, LSB = first bit received.
- valid_o  out  1  data_o and the error flags are valid.
- parity_err_o  out  1  parity mismatch on the held word.
- frame_err_o  out  1  a stop bit was sampled low.
- break_o  out  1  held word is a break condition.
- overrun_o  out  1  one-cycle pulse when a completed frame is dropped.
- busy_o  out  1  FSM is not in IDLE.

One clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.

## Operation
Input path:
- serial_i passes through 2 flops to give rx_s. Both flops reset to 1.
- MID = CLKS_PER_BIT/2, using integer division.
- Every bit state runs timer 0..CLKS_PER_BIT-1.
- rx_s is sampled at timer MID-1, MID and MID+1. The bit value is the 2-of-3 majority, decided at timer MID+1.

FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rx_s==0 → START, timer=0.
- START: if the majority at MID+1 is 1, this is a false start → IDLE. Otherwise, at timer CLKS_PER_BIT-1 → DATA, with timer=0 and bit_idx=0.
- DATA: store the majority into shift[bit_idx]. At the end of the period, go to the next bit. After bit DATA_BITS-1 → PARITY if PARITY≠0, else → STOP.
- PARITY: store the majority as par_bit. At the end of the period → STOP.
- Parity check:
  - even mode requires XOR(data, par_bit) = 0;
  - odd mode requires XOR(data, par_bit) = 1;
  - parity_err = 0 when PARITY = 0.
- STOP: every stop bit with majority 0 sets frame_err.
  - For a non-final stop bit, move on at the end of its period.
  - The final stop bit completes the frame at its timer MID+1 (early resync). Next state is WAIT_HIGH if frame_err, else IDLE.
- break = frame_err AND all data bits 0 AND (PARITY = 0 OR par_bit = 0).
- WAIT_HIGH: stays until rx_s==1, then → IDLE. A break or framing fault never re-triggers a start while the line is still low.

Output holding register:
- On frame completion, if valid_o==0, or if valid_o&&ready_i in the same cycle:
  - data_o and the three flags load;
  - valid_o = 1 the next cycle.
- Otherwise the new frame is discarded, the old word is kept, and overrun_o pulses 1 cycle.
- A transfer occurs on an edge where valid_o && ready_i. valid_o then drops unless a simultaneous completion reloads it.
- Flags are meaningful only while valid_o = 1, and change only on load.

Reset:
- Any cycle with reset = 1, including mid-frame, forces IDLE, timer = 0 and bit_idx = 0.
- All outputs reset to 0: data_o, valid_o, parity_err_o, frame_err_o, break_o, overrun_o, busy_o.
- The sync flops reset to 1.

## Timing
- Synchroniser latency: 2 cycles from serial_i to rx_s.
- Cycle 0 is the edge at which the FSM enters START.
- NBITS = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- Frame completion happens on edge (NBITS-1)·CLKS_PER_BIT + MID + 1. valid_o is high on the cycle after it.
  - Defaults: completion at edge 153; valid_o high from edge 154.
  - With PARITY = 2: completion at edge 169; valid_o from edge 170.
- busy_o is high from the cycle after START is entered until the cycle after the return to IDLE.
- A new start edge is accepted from IDLE in the very next cycle. Back-to-back frames are supported with no idle gap.
- overrun_o is a registered pulse, aligned to the cycle where valid_o would otherwise have reloaded.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, PARITY=2 (even), STOP_BITS=1.
- Send 0xA5 with parity 0 and stop 1. Required: valid_o rises at edge 170 after START entry, data_o=0xA5, all flags 0. Also inject a 1-cycle high glitch at timer 8 of bit 3: data is unchanged.
- Send 0xA5 with parity 1. Required: valid_o=1, data_o=0xA5, parity_err_o=1, frame_err_o=0.
- Drive serial_i low for 5 cycles, then high. Required: START sees majority 1, the FSM returns to IDLE, valid_o stays 0, busy_o pulses briefly.
- Hold serial_i low for 12 bit periods, then high. Required: data_o=0x00, frame_err_o=1, break_o=1. No second valid_o until the line has been high and a fresh start bit is sent.
- With ready_i=0, send 0x11 then 0x22 back-to-back. Required: data_o stays 0x11, overrun_o pulses exactly once. Then ready_i=1 for one cycle: valid_o drops the next cycle.
- Assert reset for 1 cycle during data bit 3, with the line high afterwards. Required: all outputs 0, then 0x3C is received correctly with no flags.
